subtractor_4bit_seq: RTL and testbench

//  Bit-serial sequential subtractor; the inverse of the team's 4-bit ripple-carry adder.
//  - Computes Diff = A - B - Bin, one bit per clock, LSB first, with borrow-out.
//  - Uses a single full-subtractor cell.
//  - Sits beside the adder in the arithmetic library for area-constrained datapaths.
//  - Uses a start/busy/done handshake.

---
 rtl/sub_seq_pkg.sv | 19 +
 rtl/full_subtractor_beha.sv | 16 +
 rtl/subtractor_4bit_seq.sv | 157 +++++++++++++++
 tb/tb_subtractor_4bit_seq.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sub_seq_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Holds the FSM state encoding and the counter-width helper.
// No ports; imported by subtractor_4bit_seq.
package sub_seq_pkg;

  localparam int DEF_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // The bit counter must be able to hold the value WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/full_subtractor_beha.sv
// One-bit full subtractor: d = a - b - brw, with borrow-out.
// Latency: purely combinational.
// Ports: a, b, brw (borrow-in) -> d (difference bit), brw_next (borrow-out).
module full_subtractor_beha (
  input  logic a,
  input  logic b,
  input  logic brw,
  output logic d,
  output logic brw_next
);

  assign d        = a ^ b ^ brw;
  // Borrow when b exceeds a, or when a==b and a borrow is already pending.
  assign brw_next = (~a & b) | (~(a ^ b) & brw);

endmodule

// File: rtl/subtractor_4bit_seq.sv
// Bit-serial subtractor: Diff = A - B - Bin, one bit per clock, LSB first.
// Latency: start accepted at edge 0, done pulses in the cycle after edge WIDTH+1.
// Busy handshake: start is ignored while busy=1; Diff/Bout hold until the next done.
// Ports: clk, rst_n (async, active-low), start, A, B, Bin -> busy, done, Diff, Bout,
//        and Ovf (signed overflow) only when SUB_OVERFLOW_EN is defined.
module subtractor_4bit_seq
  import sub_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             Ovf
`endif
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res;
  logic             brw;
  logic [CW-1:0]    cnt;

  logic             fs_d;
  logic             fs_brw;
  logic             load;
  logic             shift;
  logic             finish;
  logic             last_bit;

  assign last_bit = (cnt == CW'(WIDTH - 1));

  full_subtractor_beha u_fs (
    .a        (a_sr[0]),
    .b        (b_sr[0]),
    .brw      (brw),
    .d        (fs_d),
    .brw_next (fs_brw)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start)    state_nxt = S_SHIFT;
      S_SHIFT: if (last_bit) state_nxt = S_DONE;
      S_DONE:                state_nxt = S_IDLE;
      default:               state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy   = 1'b0;
    load   = 1'b0;
    shift  = 1'b0;
    finish = 1'b0;
    case (state)
      S_IDLE: begin
        load = start;
      end
      S_SHIFT: begin
        busy  = 1'b1;
        shift = 1'b1;
      end
      S_DONE: begin
        busy   = 1'b1;
        finish = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Datapath: operand shift registers, borrow, result, bit counter, outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      res  <= '0;
      brw  <= 1'b0;
      cnt  <= '0;
      Diff <= '0;
      Bout <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (load) begin
        a_sr <= A;
        b_sr <= B;
        brw  <= Bin;
        res  <= '0;
        cnt  <= '0;
      end else if (shift) begin
        a_sr <= a_sr >> 1;
        b_sr <= b_sr >> 1;
        brw  <= fs_brw;
        // Bits enter at the MSB; after WIDTH shifts bit 0 sits at the LSB.
        res  <= {fs_d, res[WIDTH-1:1]};
        cnt  <= cnt + CW'(1);
      end
      if (finish) begin
        Diff <= res;
        Bout <= brw;
        done <= 1'b1;
      end
    end
  end

`ifdef SUB_OVERFLOW_EN
  // The operand sign bits are shifted out during SHIFT, so keep copies.
  logic a_msb;
  logic b_msb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      Ovf   <= 1'b0;
    end else begin
      if (load) begin
        a_msb <= A[WIDTH-1];
        b_msb <= B[WIDTH-1];
      end
      if (finish) begin
        // Operands of opposite sign and a result whose sign differs from A.
        Ovf <= (a_msb ^ b_msb) & (a_msb ^ res[WIDTH-1]);
      end
    end
  end
`endif

endmodule

// File: tb/tb_subtractor_4bit_seq.sv
// Self-checking bench for subtractor_4bit_seq (WIDTH=4).
// A posedge reference model accepts starts and queues expected results;
// a negedge monitor pops on done and checks busy/done timing and held outputs.
module tb_subtractor_4bit_seq;

  localparam int W = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] A     = '0;
  logic [W-1:0] B     = '0;
  logic         Bin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bout;
`ifdef SUB_OVERFLOW_EN
  logic         Ovf;
`endif

  always #5 clk = ~clk;

  subtractor_4bit_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
    .Bout  (Bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .Ovf   (Ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  exp_t         sb[$];
  int           checks    = 0;
  int           failures  = 0;
  int           cnt       = 0;   // cycles left in the current operation
  bit           done_exp  = 1'b0;
  logic [W-1:0] held_diff = '0;
  logic         held_bout = 1'b0;
  logic         held_ovf  = 1'b0;

  // Plain-arithmetic reference: unsigned and signed views of A - B - Bin.
  function automatic exp_t ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic bi);
    exp_t r;
    int   u;
    int   s;
    u      = int'(a) - int'(b) - int'(bi);
    s      = int'($signed(a)) - int'($signed(b)) - int'(bi);
    r.diff = W'(u);
    r.bout = (u < 0);
    r.ovf  = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
    return r;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: an operation occupies the unit for W+1 edges after acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      = 0;
      done_exp = 1'b0;
      sb.delete();
    end else begin
      done_exp = (cnt == 1);
      if (cnt != 0) begin
        cnt--;
      end else if (start) begin
        sb.push_back(ref_model(A, B, Bin));
        cnt = W + 1;
      end
    end
  end

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      held_diff = '0;
      held_bout = 1'b0;
      held_ovf  = 1'b0;
    end else begin
      chk("busy", 32'(busy), 32'(cnt != 0));
      chk("done_timing", 32'(done), 32'(done_exp));
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_done actual=done required=no_done at %0t", $time);
        end else begin
          e         = sb.pop_front();
          held_diff = e.diff;
          held_bout = e.bout;
          held_ovf  = e.ovf;
        end
      end
      chk("diff", 32'(Diff), 32'(held_diff));
      chk("bout", 32'(Bout), 32'(held_bout));
`ifdef SUB_OVERFLOW_EN
      chk("ovf", 32'(Ovf), 32'(held_ovf));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    A   = W'($urandom);
    B   = W'($urandom);
    Bin = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20 && cnt != 0; i++) tick();
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    start = 1'b1;
    A     = a;
    B     = b;
    Bin   = bi;
    tick();
    start = 1'b0;
    scramble();
    wait_idle();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_diff"}, 32'(Diff), 32'(0));
    chk({tag, "_bout"}, 32'(Bout), 32'(0));
`ifdef SUB_OVERFLOW_EN
    chk({tag, "_ovf"}, 32'(Ovf), 32'(0));
`endif
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    // Power-on reset
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Directed cases
    op(4'd9, 4'd3, 1'b0);
    op(4'd3, 4'd9, 1'b0);
    op(4'd0, 4'd0, 1'b1);
    op(4'd0, 4'd1, 1'b0);
    op(4'd7, 4'hF, 1'b0);
    op(4'd5, 4'd2, 1'b0);
    op(4'h8, 4'd1, 1'b0);

    // Start pulsed while busy must be ignored
    start = 1'b1;
    A = 4'd5; B = 4'd1; Bin = 1'b0;
    tick();
    start = 1'b0;
    scramble();
    tick();
    start = 1'b1;
    A = 4'd0; B = 4'd7; Bin = 1'b0;
    tick();
    start = 1'b0;
    scramble();
    wait_idle();

    // Reset in the middle of SHIFT aborts the operation
    start = 1'b1;
    A = 4'd7; B = 4'd2; Bin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    op(4'd12, 4'd5, 1'b1);

    // Start held high: operations run back to back with changing operands
    start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      scramble();
      tick();
    end
    start = 1'b0;
    wait_idle();

    // Random operations
    for (int i = 0; i < 100; i++) begin
      op(W'($urandom), W'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) tick();
    end

    // Exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int bi = 0; bi < 2; bi++) begin
          op(W'(a), W'(b), 1'(bi));
        end
      end
    end

    tick();
    tick();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL pending_results actual=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
